// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter for the shared master/slave bus with a transaction
//   watchdog. One master at a time owns the bus through a one-hot, active-low
//   grant. The grant is held while an access (s_as_ low) waits for the slave
//   (s_rdy_ low). A slave that never answers is cut off after TIMEOUT cycles.
//   In that case bus_err pulses and the bus is re-arbitrated among the other
//   masters.
//
// Ports
//   clk        in   bus clock, rising edge
//   reset      in   asynchronous reset, active low
//   m_req_     in   [MASTER_CH] per-master request, active low
//   s_as_      in   muxed address strobe of the current owner, active low
//   s_rdy_     in   muxed slave ready, active low
//   m_grnt_    out  [MASTER_CH] per-master grant, active low, at most one low
//   owner      out  [IDX_W] index of current owner, holds last value when idle
//   owner_vld  out  high while a grant is asserted
//   bus_err    out  one-cycle pulse on watchdog timeout
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int MASTER_CH = 4,
  parameter int IDX_W     = 2,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MASTER_CH-1:0] m_req_,
  input  logic                 s_as_,
  input  logic                 s_rdy_,
  output logic [MASTER_CH-1:0] m_grnt_,
  output logic [IDX_W-1:0]     owner,
  output logic                 owner_vld,
  output logic                 bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_WAIT
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       last, last_nxt;
  logic [MASTER_CH-1:0]   grnt_nxt;
  logic [IDX_W-1:0]       owner_nxt;
  logic                   vld_nxt;
  logic                   err_nxt;

  logic [MASTER_CH-1:0]   cand;
  logic [IDX_W-1:0]       pos;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   handoff;

  // Round-robin search starting one past the last winner. While the bus is
  // owned, the current owner is removed from the candidates. A releasing owner
  // has its request high anyway. A timed-out owner must be skipped even if it
  // still requests. The loop runs from the farthest offset to the nearest, so
  // the nearest requester is the one left in win_idx.
  always_comb begin
    cand = ~m_req_;
    if (state != ST_IDLE) begin
      cand[owner] = 1'b0;
    end
    pos       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = MASTER_CH; i >= 1; i--) begin
      pos = IDX_W'((int'(last) + i) % MASTER_CH);
      if (cand[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  // Next-state logic. Every way the owner can give up the bus funnels into
  // handoff. That path grants the next winner at the same edge, or goes idle.
  // An idle arbiter simply takes the handoff path every cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    grnt_nxt  = m_grnt_;
    owner_nxt = owner;
    vld_nxt   = owner_vld;
    err_nxt   = 1'b0;
    handoff   = 1'b0;

    case (state)
      ST_IDLE: begin
        handoff = 1'b1;
      end
      ST_GRANTED: begin
        if (!s_as_) begin
          if (s_rdy_) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end else if (m_req_[owner]) begin
          handoff = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!s_rdy_) begin
          cnt_nxt = '0;
          if (!m_req_[owner]) begin
            state_nxt = ST_GRANTED;
          end else begin
            handoff = 1'b1;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_nxt = 1'b1;
          cnt_nxt = '0;
          handoff = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        grnt_nxt  = '1;
        vld_nxt   = 1'b0;
      end
    endcase

    if (handoff) begin
      if (win_found) begin
        state_nxt = ST_GRANTED;
        grnt_nxt  = ~(MASTER_CH'(1) << win_idx);
        owner_nxt = win_idx;
        last_nxt  = win_idx;
        vld_nxt   = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
        grnt_nxt  = '1;
        vld_nxt   = 1'b0;
      end
    end
  end

  // Reset leaves last at the top index, so master 0 is searched first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= IDX_W'(MASTER_CH - 1);
      m_grnt_   <= '1;
      owner     <= '0;
      owner_vld <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      m_grnt_   <= grnt_nxt;
      owner     <= owner_nxt;
      owner_vld <= vld_nxt;
      bus_err   <= err_nxt;
    end
  end

endmodule
